// File: rtl/gpio_pkg.sv
// Shared definitions for the N-pin GPIO controller: register offsets and the byte-lane helper.
package gpio_pkg;

    localparam int unsigned MAX_PINS = 32;

    localparam logic [31:0] GPIO_OUT     = 32'h0000_0000;
    localparam logic [31:0] GPIO_DIR     = 32'h0000_0004;
    localparam logic [31:0] GPIO_IN      = 32'h0000_0008;
    localparam logic [31:0] GPIO_IRQ_EN  = 32'h0000_000C;
    localparam logic [31:0] GPIO_RISE_EN = 32'h0000_0010;
    localparam logic [31:0] GPIO_FALL_EN = 32'h0000_0014;
    localparam logic [31:0] GPIO_STATUS  = 32'h0000_0018;
    localparam logic [31:0] GPIO_OUT_SET = 32'h0000_001C;
    localparam logic [31:0] GPIO_OUT_CLR = 32'h0000_0020;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        lane_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchroniser plus a history flop; raw (unmasked) rise/fall detection.
module gpio_sync_edge #(
    parameter int N_PINS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_PINS-1:0] i_pad,
    output logic [N_PINS-1:0] o_sync,
    output logic [N_PINS-1:0] o_rise_raw,
    output logic [N_PINS-1:0] o_fall_raw
);

    logic [N_PINS-1:0] r_meta;
    logic [N_PINS-1:0] r_sync;
    logic [N_PINS-1:0] r_prev;

    // Synchroniser chain and previous-value flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync     = r_sync;
    assign o_rise_raw = r_sync & ~r_prev;
    assign o_fall_raw = ~r_sync & r_prev;

endmodule

// File: rtl/gpio_ctrl_n.sv
// N-pin GPIO controller: local-bus register file, set/clear on OUT, synchronised inputs,
// sticky edge status with W1C and a single level interrupt.
module gpio_ctrl_n
    import gpio_pkg::*;
#(
    parameter int          N_PINS    = 16,
    parameter logic [31:0] BASE_MASK = 32'h0000_00FF,
    parameter logic [31:0] DIR_RST   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       waddr,
    input  logic [31:0]       wdata,
    input  logic              wen,
    input  logic [3:0]        wstrb,
    output logic              wready,
    input  logic [31:0]       raddr,
    input  logic              ren,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);

    logic [N_PINS-1:0] r_out;
    logic [N_PINS-1:0] r_dir;
    logic [N_PINS-1:0] r_irq_en;
    logic [N_PINS-1:0] r_rise_en;
    logic [N_PINS-1:0] r_fall_en;
    logic [N_PINS-1:0] r_status;
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              r_wready;

    logic [31:0]       w_woff;
    logic [31:0]       w_roff;
    logic [31:0]       w_lane;
    logic [N_PINS-1:0] w_wmask;
    logic [N_PINS-1:0] w_wbits;
    logic [N_PINS-1:0] w_sync;
    logic [N_PINS-1:0] w_rise_raw;
    logic [N_PINS-1:0] w_fall_raw;
    logic [N_PINS-1:0] w_edge;
    logic [N_PINS-1:0] w_w1c;
    logic [N_PINS-1:0] w_out_nx;
    logic [N_PINS-1:0] w_dir_nx;
    logic [N_PINS-1:0] w_irq_en_nx;
    logic [N_PINS-1:0] w_rise_en_nx;
    logic [N_PINS-1:0] w_fall_en_nx;
    logic [N_PINS-1:0] w_status_nx;
    logic [31:0]       w_rmux;
    logic              w_unused;

    gpio_sync_edge #(
        .N_PINS (N_PINS)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_pad      (gpio_in),
        .o_sync     (w_sync),
        .o_rise_raw (w_rise_raw),
        .o_fall_raw (w_fall_raw)
    );

    assign w_woff   = waddr & BASE_MASK;
    assign w_roff   = raddr & BASE_MASK;
    assign w_lane   = lane_mask(wstrb);
    assign w_wmask  = w_lane[N_PINS-1:0];
    assign w_wbits  = wdata[N_PINS-1:0] & w_wmask;
    assign w_edge   = (w_rise_raw & r_rise_en) | (w_fall_raw & r_fall_en);
    assign w_unused = ^{wdata, w_lane};

    // Write decode; a fresh edge is OR-ed in after the W1C so capture wins a collision.
    always_comb begin
        w_out_nx     = r_out;
        w_dir_nx     = r_dir;
        w_irq_en_nx  = r_irq_en;
        w_rise_en_nx = r_rise_en;
        w_fall_en_nx = r_fall_en;
        w_w1c        = '0;
        if (wen) begin
            case (w_woff)
                GPIO_OUT:     w_out_nx     = (r_out     & ~w_wmask) | w_wbits;
                GPIO_DIR:     w_dir_nx     = (r_dir     & ~w_wmask) | w_wbits;
                GPIO_IRQ_EN:  w_irq_en_nx  = (r_irq_en  & ~w_wmask) | w_wbits;
                GPIO_RISE_EN: w_rise_en_nx = (r_rise_en & ~w_wmask) | w_wbits;
                GPIO_FALL_EN: w_fall_en_nx = (r_fall_en & ~w_wmask) | w_wbits;
                GPIO_STATUS:  w_w1c        = w_wbits;
                GPIO_OUT_SET: w_out_nx     = r_out | w_wbits;
                GPIO_OUT_CLR: w_out_nx     = r_out & ~w_wbits;
                default:      w_w1c        = '0;
            endcase
        end else begin
            w_w1c = '0;
        end
        w_status_nx = (r_status & ~w_w1c) | w_edge;
    end

    // Read mux; write-only and unmapped offsets return zero.
    always_comb begin
        w_rmux = 32'h0000_0000;
        case (w_roff)
            GPIO_OUT:     w_rmux[N_PINS-1:0] = r_out;
            GPIO_DIR:     w_rmux[N_PINS-1:0] = r_dir;
            GPIO_IN:      w_rmux[N_PINS-1:0] = w_sync;
            GPIO_IRQ_EN:  w_rmux[N_PINS-1:0] = r_irq_en;
            GPIO_RISE_EN: w_rmux[N_PINS-1:0] = r_rise_en;
            GPIO_FALL_EN: w_rmux[N_PINS-1:0] = r_fall_en;
            GPIO_STATUS:  w_rmux[N_PINS-1:0] = r_status;
            default:      w_rmux = 32'h0000_0000;
        endcase
    end

    // Register file, status and bus handshake flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out     <= '0;
            r_dir     <= DIR_RST[N_PINS-1:0];
            r_irq_en  <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_rdata   <= 32'h0000_0000;
            r_rvalid  <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            r_out     <= w_out_nx;
            r_dir     <= w_dir_nx;
            r_irq_en  <= w_irq_en_nx;
            r_rise_en <= w_rise_en_nx;
            r_fall_en <= w_fall_en_nx;
            r_status  <= w_status_nx;
            r_rvalid  <= ren;
            r_wready  <= wen;
            if (ren) begin
                r_rdata <= w_rmux;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign wready   = r_wready;
    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_status & r_irq_en);

endmodule

// File: tb/tb_gpio_ctrl_n.sv
// Bench for gpio_ctrl_n: read data scoreboarded through a queue, other outputs checked inline.
module tb_gpio_ctrl_n;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] waddr, wdata, raddr;
    logic        wen, ren;
    logic [3:0]  wstrb;
    logic        wready, rvalid, irq;
    logic [31:0] rdata;
    logic [15:0] gpio_in, gpio_out, gpio_oe;

    logic        wready8, rvalid8, irq8;
    logic [31:0] rdata8;
    logic [7:0]  gpio_out8, gpio_oe8;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    gpio_ctrl_n #(.N_PINS(16)) dut (
        .clk(clk), .reset_n(reset_n), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_ctrl_n #(.N_PINS(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .wready(wready8), .raddr(raddr), .ren(ren), .rdata(rdata8), .rvalid(rvalid8),
        .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    // Scoreboard: every rvalid pulse of the 16-pin instance consumes one expected word.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rdata_unexpected: rvalid with no read pending, rdata=%h", rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if (rdata !== exp_v) begin
                    n_err++;
                    $display("FAIL rdata: got %h expected %h", rdata, exp_v);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr = a; wdata = d; wstrb = s; wen = 1'b1;
        tick(1);
        wen = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e);
        raddr = a; ren = 1'b1;
        exp_q.push_back(e);
        tick(1);
        ren = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        n_cmp++;
        if (irq !== 1'b0 || gpio_oe !== 16'h0000 || gpio_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: irq=%b oe=%h out=%h expected 0/0000/0000", irq, gpio_oe, gpio_out);
        end
        n_cmp++;
        if (rvalid !== 1'b0 || wready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: rvalid=%b wready=%b expected 0/0", rvalid, wready);
        end
        do_read(32'h00, 32'h0);
        do_read(32'h04, 32'h0);
        do_read(32'h08, 32'h0);
        do_read(32'h0C, 32'h0);
        do_read(32'h10, 32'h0);
        do_read(32'h14, 32'h0);
        do_read(32'h18, 32'h0);
    endtask

    task automatic test_write_strb;
        do_write(32'h04, 32'h0000_FFFF, 4'b1111);
        do_write(32'h00, 32'h0000_A5A5, 4'b0001);
        n_cmp++;
        if (wready !== 1'b1) begin
            n_err++;
            $display("FAIL wready_pulse: got %b expected 1", wready);
        end
        tick(1);
        n_cmp++;
        if (wready !== 1'b0) begin
            n_err++;
            $display("FAIL wready_single: got %b expected 0", wready);
        end
        n_cmp++;
        if (gpio_oe !== 16'hFFFF || gpio_out !== 16'h00A5) begin
            n_err++;
            $display("FAIL strb_out: oe=%h out=%h expected FFFF/00A5", gpio_oe, gpio_out);
        end
        do_read(32'h00, 32'h0000_00A5);
        do_read(32'h1000_0004, 32'h0000_FFFF);
    endtask

    task automatic test_set_clr;
        do_write(32'h00, 32'h0000_00F0, 4'b1111);
        do_write(32'h1C, 32'h0000_000F, 4'b1111);
        do_write(32'h20, 32'h0000_0030, 4'b1111);
        n_cmp++;
        if (gpio_out !== 16'h00CF) begin
            n_err++;
            $display("FAIL set_clr: gpio_out=%h expected 00CF", gpio_out);
        end
        do_read(32'h1C, 32'h0);
        do_read(32'h20, 32'h0);
        do_read(32'h00, 32'h0000_00CF);
    endtask

    task automatic test_edge_irq;
        do_write(32'h10, 32'h1, 4'b1111);
        do_write(32'h0C, 32'h1, 4'b1111);
        gpio_in[0] = 1'b1;
        tick(2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_early: got %b expected 0 after 2 clks", irq);
        end
        tick(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_rise: got %b expected 1 after 3 clks", irq);
        end
        do_read(32'h18, 32'h1);
        do_write(32'h18, 32'h1, 4'b1111);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_w1c: got %b expected 0", irq);
        end
    endtask

    task automatic test_w1c_collision;
        gpio_in[0] = 1'b0;
        tick(4);
        gpio_in[0] = 1'b1;
        tick(2);
        do_write(32'h18, 32'h1, 4'b1111);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL w1c_collision: irq=%b expected 1 (set wins)", irq);
        end
        do_read(32'h18, 32'h1);
        do_write(32'h18, 32'h1, 4'b1111);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL w1c_after: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_fall_mask;
        do_write(32'h14, 32'h2, 4'b1111);
        gpio_in[1] = 1'b1;
        tick(4);
        gpio_in[1] = 1'b0;
        tick(3);
        do_read(32'h18, 32'h2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_masked: got %b expected 0", irq);
        end
        do_write(32'h18, 32'h2, 4'b1111);
        do_read(32'h18, 32'h0);
    endtask

    task automatic test_inputs;
        gpio_in = 16'h5A3C;
        tick(3);
        do_read(32'h08, 32'h0000_5A3C);
        do_write(32'h08, 32'h0, 4'b1111);
        n_cmp++;
        if (wready !== 1'b1) begin
            n_err++;
            $display("FAIL wready_ro: got %b expected 1", wready);
        end
        do_read(32'h108, 32'h0000_5A3C);
    endtask

    task automatic test_unmapped;
        do_read(32'h3C, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rvalid_pulse: got %b expected 1", rvalid);
        end
        tick(1);
        n_cmp++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rvalid_single: rvalid=%b rdata=%h expected 0/0", rvalid, rdata);
        end
        do_write(32'h3C, 32'hFFFF_FFFF, 4'b1111);
        do_write(32'h0C, 32'hFFFF_FFFF, 4'b0010);
        do_read(32'h0C, 32'h0000_FF01);
    endtask

    task automatic test_back_to_back;
        do_write(32'h00, 32'h0000_1234, 4'b1111);
        waddr = 32'h00; wdata = 32'h0000_5678; wstrb = 4'b1111; wen = 1'b1;
        raddr = 32'h00; ren = 1'b1;
        exp_q.push_back(32'h0000_1234);
        tick(1);
        wen = 1'b0; ren = 1'b0;
        do_read(32'h00, 32'h0000_5678);
        do_read(32'h04, 32'h0000_FFFF);
    endtask

    task automatic test_n8;
        do_write(32'h00, 32'hFFFF_FFFF, 4'b1111);
        raddr = 32'h00; ren = 1'b1;
        exp_q.push_back(32'h0000_FFFF);
        tick(1);
        ren = 1'b0;
        n_cmp++;
        if (rvalid8 !== 1'b1 || rdata8 !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL n8_read: rvalid=%b rdata=%h expected 1/000000FF", rvalid8, rdata8);
        end
        n_cmp++;
        if (gpio_out8 !== 8'hFF) begin
            n_err++;
            $display("FAIL n8_out: gpio_out=%h expected FF", gpio_out8);
        end
    endtask

    task automatic test_reset_mid;
        raddr = 32'h00; ren = 1'b1;
        waddr = 32'h04; wdata = 32'h0; wstrb = 4'b1111; wen = 1'b1;
        reset_n = 1'b0;
        tick(1);
        ren = 1'b0; wen = 1'b0; reset_n = 1'b1;
        n_cmp++;
        if (rvalid !== 1'b0 || wready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: rvalid=%b wready=%b expected 0/0", rvalid, wready);
        end
        tick(1);
        n_cmp++;
        if (rvalid !== 1'b0 || wready !== 1'b0 || gpio_out !== 16'h0 || gpio_oe !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid_after: rvalid=%b wready=%b out=%h oe=%h expected all 0",
                     rvalid, wready, gpio_out, gpio_oe);
        end
        do_read(32'h0C, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; wen = 1'b0; ren = 1'b0;
        waddr = 32'h0; wdata = 32'h0; raddr = 32'h0; wstrb = 4'b0000;
        gpio_in = 16'h0000;
        test_reset;
        test_write_strb;
        test_set_clr;
        test_edge_irq;
        test_w1c_collision;
        test_fall_mask;
        test_inputs;
        test_unmapped;
        test_back_to_back;
        test_n8;
        test_reset_mid;
        tick(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_reads: %0d reads never returned, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
